user_seq_capture: RTL and testbench
===================================

Name: user_seq_capture

Overview:
- Upstream feeder of the player-input register REG_User in the Genius (Simon) game.
- Samples the four push buttons and converts each clean press into a 4-bit one-hot code.
- Packs up to 16 codes into a 64-bit sequence word, then issues a one-cycle write strobe so REG_User latches the word for comparison against the game sequence.

Parameters:
- MAX_PRESSES, 16, maximum presses per round; data width = MAX_PRESSES*4.
- SYNC_STAGES, 2, flip-flop depth of the key synchronizer.
- DEB_CYCLES, 500000, stable cycles required per key change (10 ms at 50 MHz); used only with USER_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- R  in  1  asynchronous active-high reset.
- en  in  1  level; high = capture round armed, low = abort/idle.
- round  in  4  expected presses minus one (0 -> 1 press, 15 -> 16 presses); latched at start.
- key_n  in  4  raw push buttons, active-low, asynchronous.
- data  out  64  packed sequence; press i occupies bits [4i+3:4i]; unused nibbles 0.
- E  out  1  one-cycle write strobe to REG_User; data is valid in the same cycle.
- busy  out  1  high in any state other than IDLE.
- count  out  5  presses stored so far (0..16).
- err  out  1  one-cycle pulse on a multi-key press.

Behaviour:
- Reset (R=1, asynchronous): state IDLE, data=0, count=0, E=0, busy=0, err=0, synchronizer and debounce state cleared.
- Key path: key_n inverted to pressed[3:0], then passed through SYNC_STAGES flip-flops (and the debouncer when enabled) to give kv[3:0].
- IDLE: when en=1, latch round into rnd_q, clear data and count, go to WAIT_PRESS next cycle.
- WAIT_PRESS:
  - kv==0: stay.
  - kv has exactly one bit set: write kv into nibble[count], count+1, go to WAIT_RELEASE.
  - kv has two or more bits set: err=1 for one cycle, nothing stored, count unchanged, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Stay until kv==0.
  - On kv==0: go to DONE if count==rnd_q+1, otherwise go to WAIT_PRESS.
  - Bits that change while any key is held are ignored (one press per release).
- DONE: E=1 for exactly one cycle with the final data, then IDLE. data holds its value until the next start or reset.
- en falls in any non-IDLE state: go to IDLE next cycle, no E pulse, data and count cleared.
- en held high after DONE: the IDLE->WAIT_PRESS re-arm happens on the cycle after the IDLE cycle. There is no back-to-back E.
- count never exceeds 16; rnd_q+1 is computed 5 bits wide, so round=15 gives 16.
- Writes to the nibble index use count[3:0]. The DONE check guarantees no write at count=16.
- Latency from kv change to the data/count update is 1 cycle.

Optional Feature:
- USER_DEBOUNCE_EN defined:
  - A per-vector stability counter; kv updates only after the synchronized vector has been unchanged for DEB_CYCLES consecutive cycles.
  - Any change restarts the count.
- Undefined: kv equals the synchronizer output directly, and the counter logic is absent.

Decomposition:
- Package genius_pkg:
  - state enum {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE};
  - CODE_W=4;
  - key code constants KEY_G=4'b0001, KEY_R=4'b0010, KEY_Y=4'b0100, KEY_B=4'b1000;
  - function onehot4 (exactly-one-bit check).
- Sub-module key_conditioner: synchronizer plus optional debouncer, output kv.
- The FSM and packing stay in user_seq_capture.

Test Plan:
- Reset mid-operation: R=1 asynchronously -> data=0, count=0, busy=0 immediately, with no clock edge required.
- Single-press round: round=0, en=1, press key_n=4'b1110 then release -> data=64'h1, E pulses once, count=1, busy falls.
- Four-press round: round=3, presses keys 0,1,2,3 in order -> data=64'h0000_0000_0000_8421, single E pulse after the 4th release.
- Multi-key press: round=1, key_n=4'b1100 -> err pulse, count stays 0; then presses 3 and 0 -> data=64'h18, E once.
- Abort: round=7, three presses, then en=0 -> no E, IDLE, count=0; re-arm with round=0 and one press of key 2 -> data=64'h4.
- Debounce (USER_DEBOUNCE_EN, DEB_CYCLES=4): key bounces with 2-cycle pulses -> no capture; key held 6 cycles -> exactly one nibble stored.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) player-input path.
// Holds the capture FSM state type, the per-press code width, the one-hot
// key codes and the exactly-one-bit check used to classify a press.
package genius_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_G = 4'b0001;
  localparam logic [CODE_W-1:0] KEY_R = 4'b0010;
  localparam logic [CODE_W-1:0] KEY_Y = 4'b0100;
  localparam logic [CODE_W-1:0] KEY_B = 4'b1000;

  // True when exactly one bit of v is set.
  function automatic logic onehot4(input logic [CODE_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Push-button conditioner: brings the asynchronous, already-inverted key
// vector into the clock domain through a SYNC_STAGES flop chain and, when
// USER_DEBOUNCE_EN is defined, only forwards a new vector once it has been
// stable for DEB_CYCLES consecutive cycles. Without the macro the debounce
// counter is absent and kv_o is the synchronizer output.
module key_conditioner
  import genius_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] pressed_i,
  output logic [CODE_W-1:0] kv_o
);

  logic [CODE_W-1:0] sync_q [SYNC_STAGES];
  logic [CODE_W-1:0] sync_out;

  // Multi-stage synchronizer for the raw key vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pressed_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef USER_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0]  stab_q;
  logic [CNT_W-1:0]  stab_d;
  logic [CODE_W-1:0] cand_q;
  logic [CODE_W-1:0] cand_d;
  logic [CODE_W-1:0] kv_q;
  logic [CODE_W-1:0] kv_d;

  // Stability tracking: any change of the synchronized vector restarts the
  // count; the candidate is promoted once it has held for DEB_CYCLES cycles.
  always_comb begin
    stab_d = stab_q;
    cand_d = cand_q;
    kv_d   = kv_q;
    if (sync_out != cand_q) begin
      cand_d = sync_out;
      stab_d = '0;
    end else if (stab_q != CNT_W'(DEB_CYCLES - 1)) begin
      stab_d = stab_q + 1'b1;
    end else begin
      kv_d = cand_q;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      cand_q <= '0;
      kv_q   <= '0;
    end else begin
      stab_q <= stab_d;
      cand_q <= cand_d;
      kv_q   <= kv_d;
    end
  end

  assign kv_o = kv_q;
`else
  assign kv_o = sync_out;
`endif

endmodule

// File: rtl/user_seq_capture.sv
// Player-input capture for the Genius (Simon) game. Conditions the four
// active-low push buttons, packs each clean single-key press as a one-hot
// nibble into a MAX_PRESSES*4-bit word, and strobes E for one cycle once
// round+1 presses have been stored so REG_User can latch the word.
// Optional build macro: USER_DEBOUNCE_EN (enables the key debouncer).
module user_seq_capture
  import genius_pkg::*;
#(
  parameter int unsigned MAX_PRESSES = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic                          clk,
  input  logic                          R,
  input  logic                          en,
  input  logic [3:0]                    round,
  input  logic [3:0]                    key_n,
  output logic [MAX_PRESSES*CODE_W-1:0] data,
  output logic                          E,
  output logic                          busy,
  output logic [4:0]                    count,
  output logic                          err
);

  localparam int unsigned DW = MAX_PRESSES * CODE_W;

  logic [CODE_W-1:0] kv;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        rnd_q;
  logic [3:0]        rnd_d;
  logic [DW-1:0]     data_q;
  logic [DW-1:0]     data_d;
  logic [4:0]        count_q;
  logic [4:0]        count_d;
  logic              err_q;
  logic              err_d;
  logic [4:0]        target;

  key_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_keys (
    .clk       (clk),
    .rst       (R),
    .pressed_i (~key_n),
    .kv_o      (kv)
  );

  // 5-bit press target so round=15 yields 16 presses.
  assign target = {1'b0, rnd_q} + 5'd1;

  // Capture FSM: arm on en, store one nibble per clean press, wait for full
  // release between presses, and abort with a full clear whenever en drops.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          rnd_d   = round;
          data_d  = '0;
          count_d = '0;
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!en) begin
          data_d  = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (kv != '0) begin
          if (onehot4(kv)) begin
            data_d[CODE_W*int'(count_q[3:0]) +: CODE_W] = kv;
            count_d = count_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!en) begin
          data_d  = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (kv == '0) begin
          state_d = (count_q == target) ? DONE : WAIT_PRESS;
        end
      end
      DONE: begin
        if (!en) begin
          data_d  = '0;
          count_d = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // The strobe is gated by en so an abort arriving in DONE never writes.
  assign E     = (state_q == DONE) && en;
  assign busy  = (state_q != IDLE);
  assign data  = data_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_user_seq_capture.sv
// Self-checking bench for user_seq_capture: directed scenarios plus random
// rounds compared against a queue-based model of the pressed sequence.
module tb_user_seq_capture;
  import genius_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
`ifdef USER_DEBOUNCE_EN
  localparam int unsigned SETTLE = SYNC + DEB + 5;
`else
  localparam int unsigned SETTLE = SYNC + 4;
`endif

  logic        clk = 1'b0;
  logic        R;
  logic        en;
  logic [3:0]  round;
  logic [3:0]  key_n;
  logic [63:0] data;
  logic        E;
  logic        busy;
  logic [4:0]  count;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          e_cnt   = 0;
  int          err_cnt = 0;
  logic [63:0] e_data  = '0;
  int          exp_err = 0;
  logic [3:0]  exp_q[$];

  user_seq_capture #(
    .MAX_PRESSES (16),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk   (clk),
    .R     (R),
    .en    (en),
    .round (round),
    .key_n (key_n),
    .data  (data),
    .E     (E),
    .busy  (busy),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (E) begin
      e_cnt++;
      e_data = data;
    end
    if (err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_word();
    logic [63:0] w;
    w = '0;
    foreach (exp_q[i]) w = w | (64'(exp_q[i]) << (4 * i));
    return w;
  endfunction

  task automatic start_round(input logic [3:0] r);
    exp_q.delete();
    round = r;
    en    = 1'b1;
    tick(2);
  endtask

  task automatic press_hold(input logic [3:0] code);
    key_n = ~code;
    tick(SETTLE);
    if ($countones(code) == 1) exp_q.push_back(code);
    else exp_err++;
    total++;
    if (count !== 5'(exp_q.size())) begin
      bad++;
      $display("FAIL press_count: got %0d want %0d", count, exp_q.size());
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++;
      $display("FAIL err_pulses: got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic release_normal();
    int e0;
    e0 = e_cnt;
    key_n = 4'hF;
    tick(SETTLE);
    total++;
    if (e_cnt !== e0 || count !== 5'(exp_q.size())) begin
      bad++;
      $display("FAIL early_strobe: E pulses %0d want 0, count %0d want %0d",
               e_cnt - e0, count, exp_q.size());
    end
  endtask

  task automatic release_final(input bit keep_en);
    int e0;
    bit seen;
    e0 = e_cnt;
    seen = 0;
    key_n = 4'hF;
    for (int i = 0; i < int'(SETTLE) + 6; i++) begin
      tick(1);
      if (e_cnt != e0) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL e_strobe: got no E within %0d cycles, want one", SETTLE + 6);
    end
    total++;
    if (e_data !== model_word()) begin
      bad++;
      $display("FAIL e_data: got %h want %h", e_data, model_word());
    end
    if (keep_en) begin
      tick(SETTLE);
      total++;
      if (e_cnt !== e0 + 1 || busy !== 1'b1 || count !== 5'd0) begin
        bad++;
        $display("FAIL rearm: E pulses %0d want 1, busy %b want 1, count %0d want 0",
                 e_cnt - e0, busy, count);
      end
    end else begin
      tick(1);
      en = 1'b0;
      tick(3);
      total++;
      if (e_cnt !== e0 + 1 || busy !== 1'b0 || data !== model_word()) begin
        bad++;
        $display("FAIL done_idle: E pulses %0d want 1, busy %b want 0, data %h want %h",
                 e_cnt - e0, busy, data, model_word());
      end
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    en = 1'b0;
    round = '0;
    key_n = 4'hF;
    #1;
    total++;
    if (data !== 64'h0 || count !== 5'd0 || busy !== 1'b0 || E !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: data %h count %0d busy %b E %b err %b want all zero",
               data, count, busy, E, err);
    end
    tick(3);
    R = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    start_round(4'd0);
    press_hold(KEY_G);
    release_final(0);
    total++;
    if (e_data !== 64'h1) begin
      bad++;
      $display("FAIL single_word: got %h want %h", e_data, 64'h1);
    end
  endtask

  task automatic test_four();
    logic [3:0] seq [4];
    seq = '{KEY_G, KEY_R, KEY_Y, KEY_B};
    start_round(4'd3);
    for (int i = 0; i < 4; i++) begin
      press_hold(seq[i]);
      if (i < 3) release_normal();
    end
    release_final(0);
    total++;
    if (e_data !== 64'h8421) begin
      bad++;
      $display("FAIL four_word: got %h want %h", e_data, 64'h8421);
    end
  endtask

  task automatic test_multikey();
    start_round(4'd1);
    press_hold(4'b0011);
    release_normal();
    press_hold(KEY_B);
    release_normal();
    press_hold(KEY_G);
    release_final(0);
    total++;
    if (e_data !== 64'h18) begin
      bad++;
      $display("FAIL multikey_word: got %h want %h", e_data, 64'h18);
    end
  endtask

  task automatic test_abort();
    int e0;
    start_round(4'd7);
    e0 = e_cnt;
    press_hold(KEY_R);
    release_normal();
    press_hold(KEY_B);
    release_normal();
    press_hold(KEY_Y);
    release_normal();
    en = 1'b0;
    tick(3);
    total++;
    if (e_cnt !== e0 || busy !== 1'b0 || count !== 5'd0 || data !== 64'h0) begin
      bad++;
      $display("FAIL abort: E pulses %0d want 0, busy %b want 0, count %0d want 0, data %h want 0",
               e_cnt - e0, busy, count, data);
    end
    start_round(4'd0);
    press_hold(KEY_Y);
    release_final(0);
    total++;
    if (e_data !== 64'h4) begin
      bad++;
      $display("FAIL rearm_word: got %h want %h", e_data, 64'h4);
    end
  endtask

  task automatic test_back_to_back();
    start_round(4'd1);
    press_hold(KEY_Y);
    release_normal();
    press_hold(KEY_R);
    release_final(1);
    exp_q.delete();
    press_hold(KEY_B);
    release_normal();
    press_hold(KEY_B);
    release_final(0);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] code;
    for (int rd = 0; rd < 6; rd++) begin
      r = (rd == 5) ? 4'd15 : 4'($urandom_range(0, 5));
      start_round(r);
      forever begin
        if ($urandom_range(0, 4) == 0) code = 4'($urandom_range(1, 15));
        else code = 4'(1 << $urandom_range(0, 3));
        press_hold(code);
        if (exp_q.size() == int'(r) + 1) break;
        release_normal();
      end
      release_final(0);
    end
  endtask

  task automatic test_reset_mid();
    start_round(4'd3);
    press_hold(KEY_Y);
    #2;
    R = 1'b1;
    #1;
    total++;
    if (data !== 64'h0 || count !== 5'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: data %h count %0d busy %b want all zero", data, count, busy);
    end
    key_n = 4'hF;
    en = 1'b0;
    tick(2);
    R = 1'b0;
    exp_q.delete();
    tick(2);
  endtask

`ifdef USER_DEBOUNCE_EN
  task automatic test_debounce();
    int e0;
    start_round(4'd0);
    e0 = e_cnt;
    for (int i = 0; i < 4; i++) begin
      key_n = ~KEY_R;
      tick(2);
      key_n = 4'hF;
      tick(2);
    end
    tick(SETTLE);
    total++;
    if (count !== 5'd0 || e_cnt !== e0) begin
      bad++;
      $display("FAIL bounce: count %0d want 0, E pulses %0d want 0", count, e_cnt - e0);
    end
    exp_q.push_back(KEY_R);
    key_n = ~KEY_R;
    tick(6);
    release_final(0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_four();
    test_multikey();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef USER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
